// File: rtl/tft_spi_sink_pkg.sv
// Shared definitions for the TFT SPI sink.
// Opcodes, decoder states and cursor helper.
package tft_spi_sink_pkg;

  localparam logic [7:0] ILI9341_CASET = 8'h2A;
  localparam logic [7:0] ILI9341_PASET = 8'h2B;
  localparam logic [7:0] ILI9341_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_IGNORE
  } dec_state_t;

  typedef struct packed {
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
  } win_t;

  function automatic logic [15:0] set_byte(
    input logic [15:0] v,
    input logic        hi,
    input logic [7:0]  b
  );
    set_byte = hi ? {b, v[7:0]} : {v[15:8], b};
  endfunction

endpackage

// File: rtl/tft_spi_sink_if.sv
// SPI link lines plus the decoded command and pixel streams.
// master drives the link, slave is the sink.
interface tft_spi_sink_if;
  logic        sclk;
  logic        mosi;
  logic        csn;
  logic        dcn;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pix_valid;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [15:0] pix_color;
  logic        wrap;

  modport master (
    output sclk, mosi, csn, dcn,
    input  cmd_valid, cmd_code,
    input  pix_valid, pix_x, pix_y,
    input  pix_color, wrap
  );

  modport slave (
    input  sclk, mosi, csn, dcn,
    output cmd_valid, cmd_code,
    output pix_valid, pix_x, pix_y,
    output pix_color, wrap
  );
endinterface

// File: rtl/tft_spi_byte_rx.sv
// Synchronises the SPI lines into clk and assembles bytes.
// Emits a one-cycle byte_valid with the byte and its dc flag.
module tft_spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       csn,
  input  logic       dcn,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       cs_idle
);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] csn_sr;
  logic [SYNC_STAGES-1:0] dcn_sr;

  logic       sclk_prev;
  logic       rise_q;
  logic       mosi_q;
  logic       dc_q;
  logic [6:0] shreg;
  logic [2:0] cnt;

  localparam int T = SYNC_STAGES - 1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      csn_sr  <= '1;
      dcn_sr  <= '0;
    end else begin
      sclk_sr <= {sclk_sr[T-1:0], sclk};
      mosi_sr <= {mosi_sr[T-1:0], mosi};
      csn_sr  <= {csn_sr[T-1:0], csn};
      dcn_sr  <= {dcn_sr[T-1:0], dcn};
    end
  end

  // Edge detect is registered; data lines travel alongside it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_prev <= 1'b0;
      rise_q    <= 1'b0;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b0;
      cs_idle   <= 1'b1;
    end else begin
      sclk_prev <= sclk_sr[T];
      rise_q    <= sclk_sr[T] & ~sclk_prev;
      mosi_q    <= mosi_sr[T];
      dc_q      <= dcn_sr[T];
      cs_idle   <= csn_sr[T];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg      <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_idle) begin
        cnt <= '0;
      end else if (rise_q) begin
        shreg <= {shreg[5:0], mosi_q};
        if (cnt == 3'd7) begin
          cnt        <= '0;
          byte_valid <= 1'b1;
          rx_byte    <= {shreg, mosi_q};
          rx_dc      <= dc_q;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tft_spi_sink.sv
// ILI9341-style SPI sink: decodes CASET/PASET/RAMWR
// into a windowed pixel stream; other commands are strobed.
module tft_spi_sink
  import tft_spi_sink_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rstn,
  tft_spi_sink_if.slave bus
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       cs_idle;

  tft_spi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .sclk      (bus.sclk),
    .mosi      (bus.mosi),
    .csn       (bus.csn),
    .dcn       (bus.dcn),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .rx_dc     (rx_dc),
    .cs_idle   (cs_idle)
  );

  dec_state_t  state;
  win_t        win;
  logic [15:0] cx;
  logic [15:0] cy;
  logic [2:0]  pidx;
  logic [7:0]  hi_q;
  logic        phase;

  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pix_valid;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [15:0] pix_color;
  logic        wrap;

  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_code  = cmd_code;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_x     = pix_x;
  assign bus.pix_y     = pix_y;
  assign bus.pix_color = pix_color;
  assign bus.wrap      = wrap;

  logic p_hi;
  logic p_lo;
  assign p_hi = ~pidx[0];
  assign p_lo = ~pidx[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      win       <= '0;
      cx        <= '0;
      cy        <= '0;
      pidx      <= '0;
      hi_q      <= '0;
      phase     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      wrap      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      pix_valid <= 1'b0;
      wrap      <= 1'b0;
      if (cs_idle)
        phase <= 1'b0;
      // Command bytes pre-empt whatever the decoder was doing.
      if (byte_valid && !rx_dc) begin
        cmd_valid <= 1'b1;
        cmd_code  <= rx_byte;
        pidx      <= '0;
        unique case (1'b1)
          (rx_byte == ILI9341_CASET): state <= ST_CASET;
          (rx_byte == ILI9341_PASET): state <= ST_PASET;
          (rx_byte == ILI9341_RAMWR): begin
            state <= ST_RAMWR;
            cx    <= win.xs;
            cy    <= win.ys;
            phase <= 1'b0;
          end
          default: state <= ST_IGNORE;
        endcase
      end else if (byte_valid) begin
        unique case (state)
          ST_CASET: if (pidx < 3'd4) begin
            pidx <= pidx + 3'd1;
            if (p_lo)
              win.xs <= set_byte(win.xs, p_hi, rx_byte);
            else
              win.xe <= set_byte(win.xe, p_hi, rx_byte);
          end
          ST_PASET: if (pidx < 3'd4) begin
            pidx <= pidx + 3'd1;
            if (p_lo)
              win.ys <= set_byte(win.ys, p_hi, rx_byte);
            else
              win.ye <= set_byte(win.ye, p_hi, rx_byte);
          end
          ST_RAMWR: if (!phase) begin
            hi_q  <= rx_byte;
            phase <= 1'b1;
          end else begin
            phase     <= 1'b0;
            pix_valid <= 1'b1;
            pix_x     <= cx;
            pix_y     <= cy;
            pix_color <= {hi_q, rx_byte};
            if (cx == win.xe) begin
              cx <= win.xs;
              if (cy == win.ye) begin
                cy   <= win.ys;
                wrap <= 1'b1;
              end else begin
                cy <= cy + 16'd1;
              end
            end else begin
              cx <= cx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
